// File: rtl/ll_pkg.sv
`default_nettype none
// ============================================================================
// ll_pkg : shared LocalLink flag layout and write-FSM state encoding
// Revision 1.0
// ============================================================================
package ll_pkg;

    localparam int LL_FLAG_W = 3;

    localparam int LL_SOF = 0;
    localparam int LL_EOF = 1;
    localparam int LL_ERR = 2;

    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/ll_fifo_ram.sv
`default_nettype none
// ============================================================================
// ll_fifo_ram : 2^AW x (WIDTH+flags) storage, synchronous write, async read
// Revision 1.0
// ============================================================================
module ll_fifo_ram
    import ll_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic [AW-1:0]                waddr_i,
    input  logic [WIDTH+LL_FLAG_W-1:0]   wdata_i,
    input  logic [AW-1:0]                raddr_i,
    output logic [WIDTH+LL_FLAG_W-1:0]   rdata_o
);

    logic [WIDTH+LL_FLAG_W-1:0] mem_q [2**AW];

    // No reset on the array so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/ll_pkt_fifo.sv
`default_nettype none
// ============================================================================
// ll_pkt_fifo : LocalLink FIFO with optional store-and-forward and frame drop
// Revision 1.0
// ============================================================================
module ll_pkt_fifo
    import ll_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int AW          = 4,
    parameter bit PACKET_MODE = 1'b1,
    parameter bit DROP_ERR    = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] datain,
    input  logic             sof_i,
    input  logic             eof_i,
    input  logic             error_i,
    input  logic             src_rdy_i,
    output logic             dst_rdy_o,
    output logic [WIDTH-1:0] dataout,
    output logic             sof_o,
    output logic             eof_o,
    output logic             error_o,
    output logic             src_rdy_o,
    input  logic             dst_rdy_i,
    output logic [AW:0]      space,
    output logic [AW:0]      occupied,
    output logic             drop_o
);

    localparam int          EW      = WIDTH + LL_FLAG_W;
    localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};
    localparam bit          DROP_EN = PACKET_MODE && DROP_ERR;

    wr_state_e   state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] wr_commit_q, wr_commit_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] pkt_cnt_q, pkt_cnt_d;
    logic        drop_q, drop_d;

    logic [AW:0] w_occ;
    logic        w_full;
    logic        w_wr_en;
    logic        w_overflow;
    logic        w_err_drop;
    logic        w_commit;
    logic        w_rd_en;
    logic [EW-1:0] w_rd_word;

    assign w_occ  = wr_ptr_q - rd_ptr_q;
    assign w_full = (w_occ == DEPTH);

    // ------------------------------------------------------------------
    // Write FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            state_q <= ST_ACCEPT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ACCEPT: if (w_overflow)          state_d = ST_DROP;
            ST_DROP:   if (src_rdy_i && eof_i)  state_d = ST_ACCEPT;
            default:                            state_d = ST_ACCEPT;
        endcase
    end

    // An overflowing frame with nothing committed ahead of it can never
    // complete, so it is abandoned rather than stalling the writer forever.
    always_comb begin
        dst_rdy_o  = 1'b1;
        w_wr_en    = 1'b0;
        w_overflow = 1'b0;
        unique case (state_q)
            ST_ACCEPT: begin
                dst_rdy_o  = ~w_full;
                w_wr_en    = src_rdy_i & ~w_full;
                w_overflow = PACKET_MODE && w_full && src_rdy_i && (pkt_cnt_q == '0);
            end
            ST_DROP:   dst_rdy_o = 1'b1;
            default:   dst_rdy_o = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Pointers and frame counter
    // ------------------------------------------------------------------
    assign w_err_drop = w_wr_en && eof_i && error_i && DROP_EN;
    assign w_commit   = w_wr_en && eof_i && !w_err_drop;
    assign w_rd_en    = src_rdy_o && dst_rdy_i;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        rd_ptr_d    = rd_ptr_q;
        pkt_cnt_d   = pkt_cnt_q;
        drop_d      = w_err_drop || w_overflow;

        if (w_wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_err_drop || w_overflow) begin
            wr_ptr_d = wr_commit_q;
        end
        if (w_commit || (w_wr_en && !PACKET_MODE)) begin
            wr_commit_d = wr_ptr_q + 1'b1;
        end
        if (w_rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({w_commit, w_rd_en && w_rd_word[WIDTH+LL_EOF]})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            pkt_cnt_q   <= '0;
            drop_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_q      <= drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage and read side
    // ------------------------------------------------------------------
    ll_fifo_ram #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (w_wr_en),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i ({error_i, eof_i, sof_i, datain}),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (w_rd_word)
    );

    assign dataout   = w_rd_word[WIDTH-1:0];
    assign sof_o     = w_rd_word[WIDTH+LL_SOF];
    assign eof_o     = w_rd_word[WIDTH+LL_EOF];
    assign error_o   = w_rd_word[WIDTH+LL_ERR];
    assign src_rdy_o = PACKET_MODE ? (pkt_cnt_q != '0) : (wr_commit_q != rd_ptr_q);
    assign occupied  = w_occ;
    assign space     = DEPTH - w_occ;
    assign drop_o    = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_ll_pkt_fifo.sv
`default_nettype none
// ============================================================================
// tb_ll_pkt_fifo : directed bench, packet-mode instance (a_*) and cut-through instance (b_*)
// Revision 1.0
// ============================================================================
module tb_ll_pkt_fifo;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0;

    logic [7:0] a_datain = '0, b_datain = '0;
    logic a_sof = 0, a_eof = 0, a_err = 0, a_src_rdy_i = 0, a_dst_rdy_i = 0;
    logic b_sof = 0, b_eof = 0, b_err = 0, b_src_rdy_i = 0, b_dst_rdy_i = 0;
    logic [7:0] a_dataout, b_dataout;
    logic a_sof_o, a_eof_o, a_err_o, a_src_rdy_o, a_dst_rdy_o, a_drop;
    logic b_sof_o, b_eof_o, b_err_o, b_src_rdy_o, b_dst_rdy_o, b_drop;
    logic [4:0] a_space, a_occ, b_space, b_occ;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ll_pkt_fifo #(.WIDTH(8), .AW(4), .PACKET_MODE(1'b1), .DROP_ERR(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .datain(a_datain), .sof_i(a_sof), .eof_i(a_eof), .error_i(a_err),
        .src_rdy_i(a_src_rdy_i), .dst_rdy_o(a_dst_rdy_o),
        .dataout(a_dataout), .sof_o(a_sof_o), .eof_o(a_eof_o), .error_o(a_err_o),
        .src_rdy_o(a_src_rdy_o), .dst_rdy_i(a_dst_rdy_i),
        .space(a_space), .occupied(a_occ), .drop_o(a_drop)
    );

    ll_pkt_fifo #(.WIDTH(8), .AW(4), .PACKET_MODE(1'b0), .DROP_ERR(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .datain(b_datain), .sof_i(b_sof), .eof_i(b_eof), .error_i(b_err),
        .src_rdy_i(b_src_rdy_i), .dst_rdy_o(b_dst_rdy_o),
        .dataout(b_dataout), .sof_o(b_sof_o), .eof_o(b_eof_o), .error_o(b_err_o),
        .src_rdy_o(b_src_rdy_o), .dst_rdy_i(b_dst_rdy_i),
        .space(b_space), .occupied(b_occ), .drop_o(b_drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_src_rdy_i = 0; a_sof = 0; a_eof = 0; a_err = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        tick(); tick();
        reset_n = 1;
        n_chk++; if (a_src_rdy_o !== 1'b0) begin n_fail++; $display("FAIL reset_src_rdy: got %b want 0", a_src_rdy_o); end
        n_chk++; if (a_dst_rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_dst_rdy: got %b want 1", a_dst_rdy_o); end
        n_chk++; if (a_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", a_drop); end
        n_chk++; if (a_occ !== 5'd0) begin n_fail++; $display("FAIL reset_occupied: got %0d want 0", a_occ); end
        n_chk++; if (a_space !== 5'd16) begin n_fail++; $display("FAIL reset_space: got %0d want 16", a_space); end
        n_chk++; if (b_src_rdy_o !== 1'b0) begin n_fail++; $display("FAIL reset_b_src_rdy: got %b want 0", b_src_rdy_o); end
        n_chk++; if (b_space !== 5'd16) begin n_fail++; $display("FAIL reset_b_space: got %0d want 16", b_space); end
    endtask

    task automatic test_packet();
        a_dst_rdy_i = 0;
        for (int i = 0; i < 5; i++) begin
            a_src_rdy_i = 1; a_datain = 8'(i + 1); a_sof = (i == 0); a_eof = (i == 4); a_err = 0;
            n_chk++; if (a_src_rdy_o !== 1'b0) begin n_fail++; $display("FAIL pkt_early_src_rdy[%0d]: got %b want 0", i, a_src_rdy_o); end
            tick();
        end
        a_idle();
        n_chk++; if (a_src_rdy_o !== 1'b1) begin n_fail++; $display("FAIL pkt_src_rdy_after_eof: got %b want 1", a_src_rdy_o); end
        n_chk++; if (a_occ !== 5'd5) begin n_fail++; $display("FAIL pkt_occupied: got %0d want 5", a_occ); end
        a_dst_rdy_i = 1;
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (a_dataout !== 8'(i + 1)) begin n_fail++; $display("FAIL pkt_data[%0d]: got %h want %h", i, a_dataout, 8'(i + 1)); end
            n_chk++; if (a_sof_o !== (i == 0) || a_eof_o !== (i == 4)) begin n_fail++; $display("FAIL pkt_flags[%0d]: got sof=%b eof=%b", i, a_sof_o, a_eof_o); end
            tick();
        end
        a_dst_rdy_i = 0;
        n_chk++; if (a_src_rdy_o !== 1'b0) begin n_fail++; $display("FAIL pkt_empty_src_rdy: got %b want 0", a_src_rdy_o); end
        n_chk++; if (a_occ !== 5'd0) begin n_fail++; $display("FAIL pkt_empty_occupied: got %0d want 0", a_occ); end
    endtask

    task automatic test_drop_err();
        a_dst_rdy_i = 0;
        for (int i = 0; i < 4; i++) begin
            a_src_rdy_i = 1; a_datain = 8'(8'h10 + i); a_sof = (i == 0); a_eof = (i == 3); a_err = (i == 3);
            n_chk++; if (a_drop !== 1'b0) begin n_fail++; $display("FAIL err_early_drop[%0d]: got %b want 0", i, a_drop); end
            tick();
        end
        a_idle();
        n_chk++; if (a_drop !== 1'b1) begin n_fail++; $display("FAIL err_drop_pulse: got %b want 1", a_drop); end
        n_chk++; if (a_occ !== 5'd0) begin n_fail++; $display("FAIL err_rewind_occupied: got %0d want 0", a_occ); end
        n_chk++; if (a_src_rdy_o !== 1'b0) begin n_fail++; $display("FAIL err_src_rdy: got %b want 0", a_src_rdy_o); end
        tick();
        n_chk++; if (a_drop !== 1'b0) begin n_fail++; $display("FAIL err_drop_single: got %b want 0", a_drop); end
        for (int i = 0; i < 3; i++) begin
            a_src_rdy_i = 1; a_datain = 8'(8'h20 + i); a_sof = (i == 0); a_eof = (i == 2);
            tick();
        end
        a_idle();
        n_chk++; if (a_occ !== 5'd3 || a_src_rdy_o !== 1'b1) begin n_fail++; $display("FAIL err_good_frame: got occ=%0d src_rdy=%b want 3/1", a_occ, a_src_rdy_o); end
        a_dst_rdy_i = 1;
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (a_dataout !== 8'(8'h20 + i) || a_eof_o !== (i == 2) || a_err_o !== 1'b0) begin
                n_fail++; $display("FAIL err_good_data[%0d]: got %h eof=%b err=%b want %h", i, a_dataout, a_eof_o, a_err_o, 8'(8'h20 + i));
            end
            tick();
        end
        a_dst_rdy_i = 0;
        n_chk++; if (a_src_rdy_o !== 1'b0) begin n_fail++; $display("FAIL err_after_src_rdy: got %b want 0", a_src_rdy_o); end
    endtask

    task automatic test_overflow();
        a_dst_rdy_i = 0;
        for (int i = 0; i < 16; i++) begin
            a_src_rdy_i = 1; a_datain = 8'(8'h40 + i); a_sof = (i == 0); a_eof = 0;
            n_chk++; if (a_dst_rdy_o !== 1'b1 || a_src_rdy_o !== 1'b0) begin
                n_fail++; $display("FAIL ovf_fill[%0d]: got dst_rdy=%b src_rdy=%b want 1/0", i, a_dst_rdy_o, a_src_rdy_o);
            end
            tick();
        end
        a_datain = 8'h50; a_sof = 0;
        n_chk++; if (a_dst_rdy_o !== 1'b0 || a_space !== 5'd0) begin n_fail++; $display("FAIL ovf_full: got dst_rdy=%b space=%0d want 0/0", a_dst_rdy_o, a_space); end
        tick();
        n_chk++; if (a_drop !== 1'b1) begin n_fail++; $display("FAIL ovf_drop_pulse: got %b want 1", a_drop); end
        n_chk++; if (a_occ !== 5'd0) begin n_fail++; $display("FAIL ovf_rewind_occupied: got %0d want 0", a_occ); end
        for (int i = 16; i < 20; i++) begin
            a_datain = 8'(8'h40 + i); a_eof = (i == 19);
            n_chk++; if (a_dst_rdy_o !== 1'b1 || a_src_rdy_o !== 1'b0) begin
                n_fail++; $display("FAIL ovf_discard[%0d]: got dst_rdy=%b src_rdy=%b want 1/0", i, a_dst_rdy_o, a_src_rdy_o);
            end
            if (i > 16) begin
                n_chk++; if (a_drop !== 1'b0) begin n_fail++; $display("FAIL ovf_second_drop[%0d]: got %b want 0", i, a_drop); end
            end
            tick();
        end
        a_idle();
        n_chk++; if (a_drop !== 1'b0 || a_occ !== 5'd0 || a_src_rdy_o !== 1'b0) begin
            n_fail++; $display("FAIL ovf_end: got drop=%b occ=%0d src_rdy=%b want 0/0/0", a_drop, a_occ, a_src_rdy_o);
        end
        for (int i = 0; i < 2; i++) begin
            a_src_rdy_i = 1; a_datain = 8'(8'h5A + i); a_sof = (i == 0); a_eof = (i == 1);
            n_chk++; if (a_dst_rdy_o !== 1'b1) begin n_fail++; $display("FAIL ovf_next_dst_rdy[%0d]: got %b want 1", i, a_dst_rdy_o); end
            tick();
        end
        a_idle();
        a_dst_rdy_i = 1;
        for (int i = 0; i < 2; i++) begin
            n_chk++; if (a_src_rdy_o !== 1'b1 || a_dataout !== 8'(8'h5A + i) || a_sof_o !== (i == 0) || a_eof_o !== (i == 1)) begin
                n_fail++; $display("FAIL ovf_next_data[%0d]: got rdy=%b data=%h want 1/%h", i, a_src_rdy_o, a_dataout, 8'(8'h5A + i));
            end
            tick();
        end
        a_dst_rdy_i = 0;
        n_chk++; if (a_src_rdy_o !== 1'b0) begin n_fail++; $display("FAIL ovf_next_empty: got %b want 0", a_src_rdy_o); end
    endtask

    task automatic test_cut_through();
        logic [7:0] q[$];
        logic       exp_dst;
        logic       rd;
        int         n;
        b_dst_rdy_i = 0;
        n_chk++; if (b_src_rdy_o !== 1'b0) begin n_fail++; $display("FAIL ct_initial_src_rdy: got %b want 0", b_src_rdy_o); end
        for (int i = 0; i < 16; i++) begin
            b_src_rdy_i = 1; b_datain = 8'(8'h80 + i);
            q.push_back(b_datain);
            tick();
            if (i == 0) begin
                n_chk++; if (b_src_rdy_o !== 1'b1) begin n_fail++; $display("FAIL ct_latency: got %b want 1", b_src_rdy_o); end
            end
        end
        n_chk++; if (b_dst_rdy_o !== 1'b0 || b_space !== 5'd0) begin n_fail++; $display("FAIL ct_full: got dst_rdy=%b space=%0d want 0/0", b_dst_rdy_o, b_space); end
        b_dst_rdy_i = 1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            b_src_rdy_i = (c < 24);
            b_datain = 8'(8'h90 + n);
            exp_dst = (q.size() < 16);
            rd = (q.size() > 0);
            n_chk++; if (b_dst_rdy_o !== exp_dst) begin n_fail++; $display("FAIL ct_dst_rdy[%0d]: got %b want %b", c, b_dst_rdy_o, exp_dst); end
            if (rd) begin
                n_chk++; if (b_src_rdy_o !== 1'b1 || b_dataout !== q[0]) begin
                    n_fail++; $display("FAIL ct_data[%0d]: got rdy=%b data=%h want 1/%h", c, b_src_rdy_o, b_dataout, q[0]);
                end
            end else begin
                n_chk++; if (b_src_rdy_o !== 1'b0) begin n_fail++; $display("FAIL ct_empty[%0d]: got %b want 0", c, b_src_rdy_o); end
            end
            if (b_src_rdy_i && exp_dst) begin
                q.push_back(b_datain);
                n++;
            end
            if (rd) void'(q.pop_front());
            tick();
        end
        b_src_rdy_i = 0;
        b_dst_rdy_i = 0;
    endtask

    task automatic test_clear_reset();
        for (int k = 0; k < 2; k++) begin
            a_dst_rdy_i = 0;
            for (int i = 0; i < 3; i++) begin
                a_src_rdy_i = 1; a_datain = 8'(8'h30 + i); a_sof = (i == 0); a_eof = 0;
                tick();
            end
            a_idle();
            n_chk++; if (a_occ !== 5'd3) begin n_fail++; $display("FAIL flush_pre_occupied[%0d]: got %0d want 3", k, a_occ); end
            if (k == 0) clear = 1; else reset_n = 0;
            tick();
            clear = 0; reset_n = 1;
            n_chk++; if (a_occ !== 5'd0 || a_src_rdy_o !== 1'b0 || a_dst_rdy_o !== 1'b1 || a_space !== 5'd16) begin
                n_fail++; $display("FAIL flush_state[%0d]: got occ=%0d src=%b dst=%b space=%0d want 0/0/1/16", k, a_occ, a_src_rdy_o, a_dst_rdy_o, a_space);
            end
            for (int i = 0; i < 2; i++) begin
                a_src_rdy_i = 1; a_datain = 8'(8'h61 + 2 * k + i); a_sof = (i == 0); a_eof = (i == 1);
                tick();
            end
            a_idle();
            a_dst_rdy_i = 1;
            for (int i = 0; i < 2; i++) begin
                n_chk++; if (a_src_rdy_o !== 1'b1 || a_dataout !== 8'(8'h61 + 2 * k + i) || a_sof_o !== (i == 0)) begin
                    n_fail++; $display("FAIL flush_next_data[%0d][%0d]: got rdy=%b data=%h want 1/%h", k, i, a_src_rdy_o, a_dataout, 8'(8'h61 + 2 * k + i));
                end
                tick();
            end
            a_dst_rdy_i = 0;
            n_chk++; if (a_src_rdy_o !== 1'b0) begin n_fail++; $display("FAIL flush_next_empty[%0d]: got %b want 0", k, a_src_rdy_o); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        a_dst_rdy_i = 0;
        for (int i = 0; i < 5; i++) begin
            a_src_rdy_i = 1;
            a_datain = (i < 3) ? 8'(8'hA0 + i) : 8'(8'hB0 + i - 3);
            a_sof = (i == 0 || i == 3); a_eof = (i == 2);
            tick();
        end
        a_idle();
        a_dst_rdy_i = 1;
        for (int c = 0; c < 6; c++) begin
            exp = (c < 3) ? 8'(8'hA0 + c) : 8'(8'hB0 + c - 3);
            if (c == 2) begin
                a_src_rdy_i = 1; a_datain = 8'hB2; a_eof = 1;
            end else begin
                a_idle();
            end
            n_chk++; if (a_src_rdy_o !== 1'b1 || a_dataout !== exp || a_eof_o !== (c == 2 || c == 5)) begin
                n_fail++; $display("FAIL b2b_read[%0d]: got rdy=%b data=%h eof=%b want 1/%h", c, a_src_rdy_o, a_dataout, a_eof_o, exp);
            end
            tick();
        end
        a_idle();
        a_dst_rdy_i = 0;
        n_chk++; if (a_src_rdy_o !== 1'b0 || a_occ !== 5'd0) begin n_fail++; $display("FAIL b2b_end: got src=%b occ=%0d want 0/0", a_src_rdy_o, a_occ); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_packet();
        test_drop_err();
        test_overflow();
        test_cut_through();
        test_clear_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ll_pkt_fifo.md
Name: ll_pkt_fifo

Overview:
- Parametrised successor to the 8-bit short LocalLink FIFO.
- Buffers LocalLink streams of data plus sof/eof/error, with configurable data width and depth.
- Adds an optional packet (store-and-forward) mode, which holds each frame until its eof has been written.
- Adds optional dropping of error-tagged frames and of frames that overflow the buffer.
- Sits between the MAC byte/word streams and downstream packet consumers; it is the first stage that can discard bad frames.

Parameters:
- WIDTH, 8: data bits per word.
- AW, 4: address width; storage depth is 2^AW words.
- PACKET_MODE, 1: 1 = src_rdy_o only when at least one complete frame is stored; 0 = cut-through, identical handshake to a plain FIFO.
- DROP_ERR, 1: 1 = a frame whose eof word carries error_i is discarded in full (effective only when PACKET_MODE=1).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous reset, active-low
- clear  in  1  synchronous flush, active-high
- datain  in  WIDTH  write data
- sof_i  in  1  start of frame
- eof_i  in  1  end of frame
- error_i  in  1  frame error flag
- src_rdy_i  in  1  write valid
- dst_rdy_o  out  1  write ready
- dataout  out  WIDTH  read data (first-word-fall-through)
- sof_o  out  1  start of frame
- eof_o  out  1  end of frame
- error_o  out  1  frame error flag
- src_rdy_o  out  1  read valid
- dst_rdy_i  in  1  read ready
- space  out  AW+1  free entries
- occupied  out  AW+1  stored entries, including uncommitted ones
- drop_o  out  1  one-cycle pulse when a frame is discarded

Behaviour:
- Transfer rules:
  - A write occurs when src_rdy_i & dst_rdy_o.
  - A read occurs when src_rdy_o & dst_rdy_i.
  - Storage is {error,eof,sof,data}, 2^AW entries, with combinational read at rd_ptr.
- Pointers:
  - wr_ptr, wr_commit and rd_ptr are each AW+1 bits and wrap modulo 2^(AW+1).
  - occupied = wr_ptr - rd_ptr; space = 2^AW - occupied.
  - full when occupied == 2^AW.
- pkt_cnt (AW+1 bits) counts complete committed frames.
  - +1 on commit of an eof word; -1 on read of an eof word.
  - Simultaneous +1 and -1 leaves it unchanged.
- Write FSM, states ACCEPT and DROP:
  - ACCEPT:
    - dst_rdy_o = ~full. Each write stores the word and increments wr_ptr.
    - PACKET_MODE=0: wr_commit tracks wr_ptr on every write.
    - Write with eof_i & ~(error_i & DROP_ERR): wr_commit <= wr_ptr+1, pkt_cnt += 1.
    - Write with eof_i & error_i & DROP_ERR: wr_ptr <= wr_commit (rewind) and drop_o pulses. The next cycle is ACCEPT.
    - Overflow: PACKET_MODE=1, full, src_rdy_i=1 and pkt_cnt==0. The frame cannot ever complete, so: rewind wr_ptr <= wr_commit, pulse drop_o, go to DROP.
  - DROP:
    - dst_rdy_o = 1; incoming words are discarded.
    - The eof write returns the FSM to ACCEPT, with no second drop_o pulse.
- Read side:
  - src_rdy_o = PACKET_MODE ? (pkt_cnt != 0) : (wr_commit != rd_ptr).
  - PACKET_MODE=1 uses the committed view; the read never passes wr_commit.
  - Latency (PACKET_MODE=0): a word written in cycle N gives src_rdy_o=1 in cycle N+1.
  - Latency (PACKET_MODE=1): src_rdy_o rises the cycle after the eof write.
- Simultaneous read and write at full: the write is refused (dst_rdy_o is based on registered full).
  - occupied drops by 1; the write is accepted next cycle.
- Error frames with DROP_ERR=0, or with PACKET_MODE=0, pass through with error_o set.
- No framing repair: a missing sof or eof is stored as received.
- Reset (reset_n=0 at a clk edge):
  - All pointers and pkt_cnt go to 0; FSM goes to ACCEPT.
  - Outputs: src_rdy_o=0, dst_rdy_o=1, drop_o=0, occupied=0, space=2^AW.
  - dataout and flags are don't-care while src_rdy_o=0.
  - Reset mid-frame abandons all contents.
- clear has the same effect as reset but is independent of reset_n. Reset wins when both are active.

Decomposition:
- Shared package ll_pkg:
  - localparam LL_FLAG_W=3.
  - Flag bit indices SOF=0, EOF=1, ERR=2.
  - Write-FSM state enum {ST_ACCEPT, ST_DROP}.
- One sub-module, ll_fifo_ram: 2^AW x (WIDTH+3) storage with synchronous write and asynchronous read, inferable as distributed RAM.

Test Plan:
- WIDTH=8, AW=4, PACKET_MODE=1: write a 5-byte frame 0x01..0x05 with eof on 0x05.
  - src_rdy_o stays 0 until the cycle after the eof write.
  - Read returns 0x01..0x05 with sof_o on 0x01 and eof_o on 0x05.
  - pkt_cnt ends at 0.
- Same config, DROP_ERR=1: a 4-byte frame with error_i on eof, followed by a good 3-byte frame.
  - drop_o pulses once; occupied returns to 0 after the rewind.
  - Only the 3-byte frame is read.
- Same config: a 20-byte frame (longer than 16 entries).
  - Overflow at the 17th word gives drop_o=1.
  - dst_rdy_o=1 while the remainder is discarded; src_rdy_o never asserts.
  - The next 2-byte frame is read correctly.
- PACKET_MODE=0: fill 16 words with dst_rdy_i=0.
  - dst_rdy_o=0 and space=0.
  - Assert dst_rdy_i with src_rdy_i held: one read per cycle; writes resume the cycle after the first read.
  - Data order is preserved across the pointer wrap.
- Write 3 words of a frame, then pulse clear (and separately reset_n=0) mid-frame.
  - Next cycle: occupied=0, src_rdy_o=0, dst_rdy_o=1.
  - A following complete frame is read intact.
- Back-to-back: the last word of frame A is read in the same cycle as the eof of frame B is written.
  - pkt_cnt stays 1 and src_rdy_o remains 1 without a gap.
